info_byte_serializer: RTL
=========================

# info_byte_serializer

Sits between the info RAM and the QPSK symbol mapper in `tx_top`. It reads message bytes from the info RAM and drives the `i_fetch` input of the RAM address counter. It splits each byte into 2-bit QPSK symbols (I, Q), MSB first, and emits one symbol per baud tick. A one-byte prefetch buffer hides the RAM and address-counter latency so the symbol stream is continuous.

## Interface

Parameters:
- `RAM_WIDTH`, 8, byte width of the info RAM; must be even (symbols per byte = RAM_WIDTH/2).
- `RAM_RD_LAT`, 1, cycles from address change to valid `i_ram_data`; legal range 0..3.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `enb`  in  1  block enable; same signal as the address counter's `enb`.
- `i_baud_tick`  in  1  one-cycle strobe, one per symbol period.
- `i_ram_data`  in  RAM_WIDTH  info RAM read data for the current address.
- `o_fetch`  out  1  registered one-cycle pulse that advances the RAM address counter.
- `o_sym_i`  out  1  in-phase bit of the current symbol.
- `o_sym_q`  out  1  quadrature bit of the current symbol.
- `o_sym_valid`  out  1  one-cycle pulse marking a new symbol on `o_sym_i`/`o_sym_q`.
- `o_underrun`  out  1  sticky flag: a baud tick arrived with no data to send.

## Operation

- Internal state:
  - `shift_reg` (RAM_WIDTH) and `shift_cnt` (symbols remaining, 0..RAM_WIDTH/2).
  - `next_byte` (RAM_WIDTH) and `next_valid`.
  - `wcnt` (wait counter, 0..RAM_RD_LAT+1).
- `rst`, or `enb` low, flushes the block:
  - all outputs 0, `shift_cnt`=0, `next_valid`=0;
  - `wcnt`=RAM_RD_LAT, matching the address counter's return to address 0.
- When `enb` is high, the following apply each cycle.
- `wcnt` decrement: if `wcnt`≠0, decrement it.
- Prefetch capture: if `wcnt`=0 and `next_valid`=0:
  - `next_byte` ← `i_ram_data`, `next_valid` ← 1;
  - `o_fetch` ← 1 for the next cycle;
  - `wcnt` ← RAM_RD_LAT+1.
- `o_fetch` is 0 in every other cycle.
- Shift load: if `shift_cnt`=0 and `next_valid`=1:
  - `shift_reg` ← `next_byte`, `shift_cnt` ← RAM_WIDTH/2, `next_valid` ← 0.
  - This needs no baud tick.
- Symbol emit: if `i_baud_tick` and `shift_cnt`≠0:
  - `o_sym_i` ← `shift_reg[RAM_WIDTH-1]`, `o_sym_q` ← `shift_reg[RAM_WIDTH-2]`;
  - `o_sym_valid` ← 1;
  - `shift_reg` shifts left by 2, `shift_cnt` decrements.
  - If the emit leaves `shift_cnt` at 0 and `next_valid`=1, the shift load happens on the same edge, so there is no gap.
- Underrun: if `i_baud_tick` and `shift_cnt`=0:
  - `o_underrun` ← 1;
  - `o_sym_valid` stays 0;
  - `o_sym_i`/`o_sym_q` hold their values.
- Same-edge events:
  - Capture and shift load on the same edge: the load takes the old `next_byte`. This cannot occur in practice, because capture requires `next_valid`=0.
  - Capture and emit on the same edge are independent.
- `o_sym_i`/`o_sym_q` hold their values between `o_sym_valid` pulses.
- `o_underrun` clears only on `rst` or when `enb` is low.
- Message wrap-around is handled entirely by the address counter; this block streams endlessly.

## Timing

- Take edge 0 as the first edge sampled with `enb`=1 after a flush.
- Sequence for RAM_RD_LAT=1:

  - Edge 0: `wcnt` goes 1→0.
  - Edge 1: byte 0 (address 0) is captured; `o_fetch` is high between edge 1 and edge 2.
  - Edge 2: byte 0 moves into `shift_reg`.
  - Edge 4: byte 1 is captured; `o_fetch` is high between edge 4 and edge 5.
- General rule: after a capture edge E, the next capture occurs no earlier than edge E+RAM_RD_LAT+2.
- Capture latency is therefore ≤ RAM_RD_LAT+2 cycles, well under one byte period whenever the baud period ≥ 2 cycles.
- Latency from `i_baud_tick` to `o_sym_valid` is 1 cycle, registered.
- Reset in mid-operation discards both buffered bytes; no `o_fetch` is issued during or on the edge of reset.

## Test plan

- Single byte, RAM_RD_LAT=1, RAM[0]=0xB4, ticks every 4 cycles from cycle 3:
  - symbols (I,Q) = (1,0), (1,1), (0,1), (0,0);
  - `o_fetch` pulses in the cycles after edge 1 and edge 4.
- Continuous stream, RAM = 0xB4, 0x1E with the address counter connected and msg_long=1:
  - output repeats 10 11 01 00 00 01 11 10 with no gaps;
  - exactly one `o_fetch` per byte;
  - address wraps 1→0.
- Ticks on consecutive cycles from edge 0:
  - ticks before the first shift load (edge 2) raise `o_underrun`, which then stays 1;
  - `o_sym_valid` is 0 on those ticks.
- `enb` drops after the 2nd symbol of byte 0:
  - all outputs go to 0 the next cycle;
  - on re-enable, the stream restarts at byte 0 MSB with `o_underrun`=0.
- `rst` pulse in mid-stream with `o_fetch` pending:
  - outputs are 0 after the reset edge;
  - no `o_fetch` is asserted during reset.
- RAM_RD_LAT=0 and RAM_RD_LAT=3:
  - `o_fetch` spacing is 2 and 5 cycles respectively;
  - the symbol sequence is identical to the first scenario.

Source files
------------

// File: rtl/info_byte_serializer.sv
// Info RAM to QPSK serializer: prefetches one byte ahead of the shift register
// and emits one (I,Q) bit pair per baud tick, MSB first.
module info_byte_serializer #(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic                 i_baud_tick,
  input  logic [RAM_WIDTH-1:0] i_ram_data,
  output logic                 o_fetch,
  output logic                 o_sym_i,
  output logic                 o_sym_q,
  output logic                 o_sym_valid,
  output logic                 o_underrun
);

  localparam int SYMS   = RAM_WIDTH / 2;
  localparam int CNT_W  = $clog2(SYMS + 1);
  localparam int WCNT_W = $clog2(RAM_RD_LAT + 2);

  localparam logic [CNT_W-1:0]  SYMS_C      = CNT_W'(SYMS);
  localparam logic [WCNT_W-1:0] WCNT_FLUSH  = WCNT_W'(RAM_RD_LAT);
  localparam logic [WCNT_W-1:0] WCNT_RELOAD = WCNT_W'(RAM_RD_LAT + 1);

  logic [RAM_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]     shift_cnt;
  logic [RAM_WIDTH-1:0] next_byte;
  logic                 next_valid;
  logic [WCNT_W-1:0]    wcnt;

  logic                 capture;
  logic                 emit;
  logic                 load;
  logic [RAM_WIDTH-1:0] shift_after;
  logic [CNT_W-1:0]     cnt_after;

  // The shift load looks at the count as it stands after this edge's emit,
  // so the last symbol of one byte and the load of the next share an edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    capture     = 1'b0;
    emit        = 1'b0;
    load        = 1'b0;
    shift_after = shift_reg;
    cnt_after   = shift_cnt;

    capture = (wcnt == '0) && !next_valid;
    emit    = i_baud_tick && (shift_cnt != '0);
    if (emit) begin
      shift_after = shift_reg << 2;
      cnt_after   = shift_cnt - CNT_W'(1);
    end
    load = (cnt_after == '0) && next_valid;
  end

  always_ff @(posedge clk) begin
    if (rst || !enb) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      o_fetch     <= 1'b0;
      o_sym_i     <= 1'b0;
      o_sym_q     <= 1'b0;
      o_sym_valid <= 1'b0;
      o_underrun  <= 1'b0;
      shift_cnt   <= '0;
      next_valid  <= 1'b0;
      wcnt        <= WCNT_FLUSH;
      // NOTE: shift_reg and next_byte are data-only storage guarded by shift_cnt/next_valid, so they are left unreset.
    end else begin
      o_fetch     <= capture;
      o_sym_valid <= emit;
      if (emit) begin
        {o_sym_i, o_sym_q} <= shift_reg[RAM_WIDTH-1 -: 2];
      end
      if (i_baud_tick && (shift_cnt == '0)) begin
        o_underrun <= 1'b1;
      end

      if (capture) begin
        next_byte <= i_ram_data;
        wcnt      <= WCNT_RELOAD;
      end else if (wcnt != '0) begin
        wcnt <= wcnt - WCNT_W'(1);
      end

      if (capture) begin
        next_valid <= 1'b1;
      end else if (load) begin
        next_valid <= 1'b0;
      end

      if (load) begin
        shift_reg <= next_byte;
        shift_cnt <= SYMS_C;
      end else begin
        shift_reg <= shift_after;
        shift_cnt <= cnt_after;
      end
    end
  end

endmodule
